seg_display_mux: RTL and testbench

SEG_DISPLAY_MUX -- requirements
Module: seg_display_mux

---
 rtl/seg_display_mux.sv | 143 ++++++++++++++
 tb/tb_seg_display_mux.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_display_mux.sv
// -----------------------------------------------------------------------------
// seg_display_mux
//   Time-multiplexed driver for a 4-digit common-anode 7-segment display
//   showing MM:SS in BCD. A refresh counter steps a 2-bit scan index through
//   the four digit slots. anode and cathode are both registered, so they
//   always change together on the same edge.
//
//   Optional feature (macro SEG_BLINK_EN): while ADJ is high, the field
//   chosen by SEL (0 = minutes, 1 = seconds) blinks at a rate set by
//   BLINK_DIV. In the default build (macro undefined) ADJ and SEL are ignored.
//
// Parameters
//   REFRESH_DIV  clk cycles per digit slot
//   BLINK_DIV    clk cycles per blink half-period (SEG_BLINK_EN only)
//
// Ports
//   clk      in   system clock, rising edge
//   RESET_N  in   synchronous active-low reset
//   digits   in   [15:12] min tens, [11:8] min ones, [7:4] sec tens, [3:0] sec ones
//   ADJ      in   adjust-mode level (debounced)
//   SEL      in   field select, 0 = minutes, 1 = seconds (debounced)
//   anode    out  active-low digit enables, bit 0 = rightmost digit
//   cathode  out  active-low segments, bit 0 = a ... bit 6 = g
// -----------------------------------------------------------------------------
module seg_display_mux #(
  parameter int REFRESH_DIV = 400000,
  parameter int BLINK_DIV   = 25000000
) (
  input  logic        clk,
  input  logic        RESET_N,
  input  logic [15:0] digits,
  input  logic        ADJ,
  input  logic        SEL,
  output logic [3:0]  anode,
  output logic [6:0]  cathode
);

  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [RW-1:0] REFRESH_MAX = RW'(REFRESH_DIV - 1);

  // BCD to active-low segments (g..a); codes 10-15 blank the digit.
  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  logic [RW-1:0] refresh_q, refresh_d;
  logic [1:0]    idx_q, idx_d;
  logic [3:0]    anode_q, anode_d;
  logic [6:0]    cathode_q, cathode_d;
  logic          tick;
  logic [3:0]    nib;
  logic          blank;

`ifdef SEG_BLINK_EN
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);

  logic [BW-1:0] blink_q, blink_d;
  logic          phase_on_q, phase_on_d;

  // Blink timing only runs in adjust mode; leaving it restarts with the
  // field visible so re-entering adjust mode always begins "on".
  always_comb begin
    blink_d    = '0;
    phase_on_d = 1'b1;
    if (ADJ) begin
      if (blink_q == BLINK_MAX) begin
        blink_d    = '0;
        phase_on_d = ~phase_on_q;
      end else begin
        blink_d    = blink_q + 1'b1;
        phase_on_d = phase_on_q;
      end
    end
  end

  // idx_q[1] set means a minutes digit (slots 2,3). ADJ is used live so a
  // falling ADJ unblanks on the very next edge.
  assign blank = ADJ && !phase_on_q && (SEL ? !idx_q[1] : idx_q[1]);

  always_ff @(posedge clk) begin
    if (!RESET_N) begin
      blink_q    <= '0;
      phase_on_q <= 1'b1;
    end else begin
      blink_q    <= blink_d;
      phase_on_q <= phase_on_d;
    end
  end
`else
  logic unused_blink_inputs;
  assign unused_blink_inputs = ^{ADJ, SEL};
  assign blank = 1'b0;
`endif

  always_comb begin
    tick      = (refresh_q == REFRESH_MAX);
    refresh_d = tick ? '0 : refresh_q + 1'b1;
    idx_d     = tick ? idx_q + 2'd1 : idx_q;

    case (idx_q)
      2'd0:    nib = digits[3:0];
      2'd1:    nib = digits[7:4];
      2'd2:    nib = digits[11:8];
      default: nib = digits[15:12];
    endcase

    // Both outputs are derived from the same index value so they switch
    // together; digits is used live, so mid-slot changes show next edge.
    anode_d   = ~(4'b0001 << idx_q);
    cathode_d = blank ? 7'b1111111 : seg7(nib);
  end

  always_ff @(posedge clk) begin
    if (!RESET_N) begin
      refresh_q <= '0;
      idx_q     <= 2'd0;
      anode_q   <= 4'b1111;
      cathode_q <= 7'b1111111;
    end else begin
      refresh_q <= refresh_d;
      idx_q     <= idx_d;
      anode_q   <= anode_d;
      cathode_q <= cathode_d;
    end
  end

  assign anode   = anode_q;
  assign cathode = cathode_q;

endmodule

// File: tb/tb_seg_display_mux.sv
module tb_seg_display_mux;

  localparam int R = 4;
  localparam int B = 16;

  logic        clk = 1'b0;
  logic        RESET_N = 1'b0;
  logic [15:0] digits = 16'h0000;
  logic        ADJ = 1'b0;
  logic        SEL = 1'b0;
  logic [3:0]  anode;
  logic [6:0]  cathode;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model state: edges since reset release, and consecutive
  // ADJ-high edges (blink timing).
  int          n_rel = 0;
  int          m_adj = 0;
  logic [3:0]  exp_an;
  logic [6:0]  exp_cat;
  logic [6:0]  seg_tab [16];

  seg_display_mux #(.REFRESH_DIV(R), .BLINK_DIV(B)) dut (
    .clk(clk), .RESET_N(RESET_N), .digits(digits), .ADJ(ADJ), .SEL(SEL),
    .anode(anode), .cathode(cathode)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, run=%0d failed=%0d", tests_run, tests_failed);
    $fatal(1);
  end

  // Advance one clock, computing the expected registered outputs from the
  // inputs present at that edge, then settle 1 time unit past the edge.
  task automatic tick();
    int idx;
    int nib;
    @(posedge clk);
    if (!RESET_N) begin
      exp_an  = 4'b1111;
      exp_cat = 7'b1111111;
      n_rel   = 0;
      m_adj   = 0;
    end else begin
      idx     = (n_rel / R) % 4;
      exp_an  = ~(4'b0001 << idx);
      nib     = (int'(digits) >> (4 * idx)) & 15;
      exp_cat = seg_tab[nib];
`ifdef SEG_BLINK_EN
      if (ADJ && (((m_adj / B) % 2) == 1) && (SEL == (idx < 2)))
        exp_cat = 7'b1111111;
      m_adj = ADJ ? m_adj + 1 : 0;
`endif
      n_rel++;
    end
    #1;
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    digits  = 16'h1234;
    for (int i = 0; i < 2; i++) begin
      tick();
      tests_run++;
      if (anode !== 4'b1111) begin
        tests_failed++;
        $display("FAIL reset_anode cyc=%0d got=%b want=1111", i, anode);
      end
      tests_run++;
      if (cathode !== 7'b1111111) begin
        tests_failed++;
        $display("FAIL reset_cathode cyc=%0d got=%b want=1111111", i, cathode);
      end
    end
    RESET_N = 1'b1;
    tick();
    tests_run++;
    if (anode !== 4'b1110) begin
      tests_failed++;
      $display("FAIL release_anode got=%b want=1110", anode);
    end
    tests_run++;
    if (cathode !== 7'b0011001) begin
      tests_failed++;
      $display("FAIL release_cathode got=%b want=0011001", cathode);
    end
  endtask

  task automatic test_scan();
    digits = 16'h1234;
    for (int i = 0; i < 40; i++) begin
      tick();
      tests_run++;
      if (anode !== exp_an || cathode !== exp_cat) begin
        tests_failed++;
        $display("FAIL scan cyc=%0d got=%b/%b want=%b/%b", i, anode, cathode, exp_an, exp_cat);
      end
    end
  endtask

  task automatic test_blank_nibbles();
    digits = 16'h00AF;
    for (int i = 0; i < 20; i++) begin
      tick();
      tests_run++;
      if (anode !== exp_an || cathode !== exp_cat) begin
        tests_failed++;
        $display("FAIL blank_nibbles cyc=%0d got=%b/%b want=%b/%b", i, anode, cathode, exp_an, exp_cat);
      end
    end
  endtask

  task automatic test_random_digits();
    for (int i = 0; i < 200; i++) begin
      digits = 16'($urandom);
      tick();
      tests_run++;
      if (anode !== exp_an || cathode !== exp_cat) begin
        tests_failed++;
        $display("FAIL random_digits cyc=%0d dig=%h got=%b/%b want=%b/%b", i, digits, anode, cathode, exp_an, exp_cat);
      end
    end
  endtask

  task automatic test_adj_sel();
`ifdef SEG_BLINK_EN
    digits = 16'h5959;
    ADJ    = 1'b1;
    SEL    = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (i == 50) SEL = 1'b1;
      tick();
      tests_run++;
      if (anode !== exp_an || cathode !== exp_cat) begin
        tests_failed++;
        $display("FAIL blink cyc=%0d sel=%b got=%b/%b want=%b/%b", i, SEL, anode, cathode, exp_an, exp_cat);
      end
    end
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) == 0) ADJ = ~ADJ;
      if ($urandom_range(0, 19) == 0) SEL = ~SEL;
      digits = 16'($urandom);
      tick();
      tests_run++;
      if (anode !== exp_an || cathode !== exp_cat) begin
        tests_failed++;
        $display("FAIL blink_random cyc=%0d adj=%b sel=%b got=%b/%b want=%b/%b", i, ADJ, SEL, anode, cathode, exp_an, exp_cat);
      end
    end
`else
    for (int i = 0; i < 120; i++) begin
      ADJ    = 1'($urandom);
      SEL    = 1'($urandom);
      digits = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      tick();
      tests_run++;
      if (anode !== exp_an || cathode !== exp_cat) begin
        tests_failed++;
        $display("FAIL adj_ignored cyc=%0d got=%b/%b want=%b/%b", i, anode, cathode, exp_an, exp_cat);
      end
      tests_run++;
      if (cathode === 7'b1111111) begin
        tests_failed++;
        $display("FAIL never_blank cyc=%0d got=%b want=non-blank", i, cathode);
      end
    end
`endif
    ADJ = 1'b0;
    SEL = 1'b0;
  endtask

  task automatic test_reset_mid_slot();
    int guard;
    digits = 16'h4321;
    guard  = 0;
    while (!(((n_rel / R) % 4) == 2 && (n_rel % R) == 1) && guard < 64) begin
      tick();
      guard++;
    end
    tests_run++;
    if (guard >= 64) begin
      tests_failed++;
      $display("FAIL reset_mid_slot_reach got=timeout want=index2");
    end
    RESET_N = 1'b0;
    tick();
    tests_run++;
    if (anode !== 4'b1111 || cathode !== 7'b1111111) begin
      tests_failed++;
      $display("FAIL reset_mid_slot got=%b/%b want=1111/1111111", anode, cathode);
    end
    RESET_N = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 0) begin
        tests_run++;
        if (anode !== 4'b1110 || cathode !== 7'b1111001) begin
          tests_failed++;
          $display("FAIL restart_idx0 got=%b/%b want=1110/1111001", anode, cathode);
        end
      end
      tests_run++;
      if (anode !== exp_an || cathode !== exp_cat) begin
        tests_failed++;
        $display("FAIL restart_scan cyc=%0d got=%b/%b want=%b/%b", i, anode, cathode, exp_an, exp_cat);
      end
    end
  endtask

  initial begin
    seg_tab[0]  = 7'b1000000;
    seg_tab[1]  = 7'b1111001;
    seg_tab[2]  = 7'b0100100;
    seg_tab[3]  = 7'b0110000;
    seg_tab[4]  = 7'b0011001;
    seg_tab[5]  = 7'b0010010;
    seg_tab[6]  = 7'b0000010;
    seg_tab[7]  = 7'b1111000;
    seg_tab[8]  = 7'b0000000;
    seg_tab[9]  = 7'b0010000;
    for (int k = 10; k < 16; k++) seg_tab[k] = 7'b1111111;

    test_reset();
    test_scan();
    test_blank_nibbles();
    test_random_digits();
    test_adj_sel();
    test_reset_mid_slot();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
